// File: rtl/zone_tx_pkg.sv
// Shared types and constants for the MiniLED zone backlight transmitter.
// ZONE_TX_PARITY_EN appends an even-parity bit after each zone's LSB.
package zone_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } tx_state_e;

    localparam int ZONES_DEF = 360;
    localparam int DW_DEF    = 8;

    // Bit cells per zone on the serial link.
    function automatic int zone_bits(input int dw);
`ifdef ZONE_TX_PARITY_EN
        return dw + 1;
`else
        return dw;
`endif
    endfunction

endpackage

// File: rtl/zone_dpram.sv
// Ping-pong zone store: two banks of ZONES x DW, one write port, one registered read port.
// Address is {bank, idx}; contents are never reset.
module zone_dpram
    import zone_tx_pkg::*;
#(
    parameter int ZONES = ZONES_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [9:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [9:0]    rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [2][ZONES];
    logic [DW-1:0] rd_data_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr[9]][wr_addr[8:0]] <= wr_data;
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr[9]][rd_addr[8:0]];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/zone_bl_tx.sv
// Zone backlight transmitter: captures zone brightness into a ping-pong RAM and shifts
// each completed frame MSB-first to the LED driver chain. Option: ZONE_TX_PARITY_EN.
module zone_bl_tx
    import zone_tx_pkg::*;
#(
    parameter int ZONES     = ZONES_DEF,
    parameter int DW        = DW_DEF,
    parameter int CLK_DIV   = 4,
    parameter int LATCH_CYC = 8
) (
    input  logic          i_pix_clk,
    input  logic          rst,
    input  logic          zone_valid,
    input  logic [8:0]    zone_idx,
    input  logic [DW-1:0] zone_data,
    input  logic          frame_sync,
    output logic          led_sclk,
    output logic          led_sdo,
    output logic          led_latch,
    output logic          busy,
    output logic          frame_drop
);

    localparam int             NB         = zone_bits(DW);
    localparam int             DCW        = $clog2(CLK_DIV) + 1;
    localparam int             LCW        = $clog2(LATCH_CYC) + 1;
    localparam logic [8:0]     LAST_IDX   = 9'(ZONES - 1);
    localparam logic [8:0]     ZONES_W    = 9'(ZONES);
    localparam logic [DCW-1:0] DIV_LAST   = DCW'(CLK_DIV - 1);
    localparam logic [LCW-1:0] LATCH_LAST = LCW'(LATCH_CYC - 1);
    localparam logic [3:0]     BIT_LAST   = 4'(NB - 1);

    tx_state_e      state_r, state_nxt_s;
    logic           sync_q_r, sync_edge_s;
    logic           wr_bank_r, rd_bank_r;
    logic           load_ph_r;
    logic [8:0]     tx_idx_r;
    logic [3:0]     bit_cnt_r;
    logic [DCW-1:0] div_cnt_r;
    logic [LCW-1:0] lat_cnt_r;
    logic [NB-1:0]  sh_r, word_s;
    logic           sclk_r, sdo_r, latch_r, busy_r, drop_r;
    logic           sclk_nxt_s, sdo_nxt_s;
    logic           cell_end_s, wr_en_s, rd_en_s;
    logic [DW-1:0]  rd_data_s;

`ifdef ZONE_TX_PARITY_EN
    function automatic logic even_par(input logic [DW-1:0] d);
        return ^d;
    endfunction
    assign word_s = {rd_data_s, even_par(rd_data_s)};
`else
    assign word_s = rd_data_s;
`endif

    assign sync_edge_s = frame_sync & ~sync_q_r;
    assign wr_en_s     = zone_valid && (zone_idx < ZONES_W);
    assign rd_en_s     = (state_r == LOAD) && !load_ph_r;
    assign cell_end_s  = (state_r == SHIFT) && (div_cnt_r == DIV_LAST) && sclk_r;

    zone_dpram #(.ZONES(ZONES), .DW(DW)) u_ram (
        .clk     (i_pix_clk),
        .wr_en   (wr_en_s),
        .wr_addr ({wr_bank_r, zone_idx}),
        .wr_data (zone_data),
        .rd_en   (rd_en_s),
        .rd_addr ({rd_bank_r, tx_idx_r}),
        .rd_data (rd_data_s)
    );

    // FSM state register.
    always_ff @(posedge i_pix_clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (sync_edge_s) state_nxt_s = LOAD;
                else             state_nxt_s = IDLE;
            end
            LOAD: begin
                if (load_ph_r) state_nxt_s = SHIFT;
                else           state_nxt_s = LOAD;
            end
            SHIFT: begin
                if (cell_end_s && (bit_cnt_r == 4'd0)) begin
                    if (tx_idx_r == 9'd0) state_nxt_s = LATCH;
                    else                  state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            LATCH: begin
                if (lat_cnt_r == LATCH_LAST) state_nxt_s = IDLE;
                else                         state_nxt_s = LATCH;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered serial pins.
    always_comb begin
        sclk_nxt_s = 1'b0;
        sdo_nxt_s  = sdo_r;
        if ((state_r == SHIFT) && (state_nxt_s == SHIFT)) begin
            if (div_cnt_r == DIV_LAST) sclk_nxt_s = ~sclk_r;
            else                       sclk_nxt_s = sclk_r;
        end else begin
            sclk_nxt_s = 1'b0;
        end
        // sdo only moves as sclk falls; a fresh zone presents its MSB on entry to SHIFT.
        if ((state_nxt_s == IDLE) || (state_nxt_s == LATCH)) begin
            sdo_nxt_s = 1'b0;
        end else if ((state_r == LOAD) && load_ph_r) begin
            sdo_nxt_s = word_s[NB-1];
        end else if (cell_end_s && (bit_cnt_r != 4'd0)) begin
            sdo_nxt_s = sh_r[NB-1];
        end else begin
            sdo_nxt_s = sdo_r;
        end
    end

    // Datapath: bank pointers, counters, shift register and registered outputs.
    always_ff @(posedge i_pix_clk) begin
        if (rst) begin
            sync_q_r  <= 1'b0;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b1;
            load_ph_r <= 1'b0;
            tx_idx_r  <= 9'd0;
            bit_cnt_r <= 4'd0;
            div_cnt_r <= {DCW{1'b0}};
            lat_cnt_r <= {LCW{1'b0}};
            sh_r      <= {NB{1'b0}};
            sclk_r    <= 1'b0;
            sdo_r     <= 1'b0;
            latch_r   <= 1'b0;
            busy_r    <= 1'b0;
            drop_r    <= 1'b0;
        end else begin
            sync_q_r <= frame_sync;
            sclk_r   <= sclk_nxt_s;
            sdo_r    <= sdo_nxt_s;
            latch_r  <= (state_nxt_s == LATCH);
            busy_r   <= (state_nxt_s != IDLE);
            drop_r   <= sync_edge_s && (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    load_ph_r <= 1'b0;
                    if (sync_edge_s) begin
                        rd_bank_r <= wr_bank_r;
                        wr_bank_r <= ~wr_bank_r;
                        tx_idx_r  <= LAST_IDX;
                    end
                end
                LOAD: begin
                    load_ph_r <= ~load_ph_r;
                    if (load_ph_r) begin
                        sh_r      <= {word_s[NB-2:0], 1'b0};
                        bit_cnt_r <= BIT_LAST;
                        div_cnt_r <= {DCW{1'b0}};
                    end
                end
                SHIFT: begin
                    lat_cnt_r <= {LCW{1'b0}};
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= {DCW{1'b0}};
                        if (sclk_r) begin
                            if (bit_cnt_r != 4'd0) begin
                                bit_cnt_r <= bit_cnt_r - 4'd1;
                                sh_r      <= {sh_r[NB-2:0], 1'b0};
                            end else if (tx_idx_r != 9'd0) begin
                                tx_idx_r <= tx_idx_r - 9'd1;
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + {{(DCW-1){1'b0}}, 1'b1};
                    end
                end
                LATCH: begin
                    lat_cnt_r <= lat_cnt_r + {{(LCW-1){1'b0}}, 1'b1};
                end
                default: begin
                    load_ph_r <= 1'b0;
                end
            endcase
        end
    end

    assign led_sclk   = sclk_r;
    assign led_sdo    = sdo_r;
    assign led_latch  = latch_r;
    assign busy       = busy_r;
    assign frame_drop = drop_r;

endmodule

// File: tb/tb_zone_bl_tx.sv
// Scoreboard bench for zone_bl_tx: frames pushed at sync time, serial words checked by a monitor.
module tb_zone_bl_tx;

    localparam int ZONES     = 360;
    localparam int DW        = 8;
    localparam int CLK_DIV   = 1;
    localparam int LATCH_CYC = 2;
`ifdef ZONE_TX_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif
    localparam int FRAME_CYC = ZONES * (2 + NB * 2 * CLK_DIV) + LATCH_CYC;

    logic       i_pix_clk  = 1'b0;
    logic       rst        = 1'b1;
    logic       zone_valid = 1'b0;
    logic [8:0] zone_idx   = 9'd0;
    logic [7:0] zone_data  = 8'd0;
    logic       frame_sync = 1'b0;
    logic       led_sclk, led_sdo, led_latch, busy, frame_drop;

    int errors = 0;
    int checks = 0;

    logic [7:0] mdl [2][ZONES];
    logic       mwb = 1'b0;
    logic [8:0] exp_q [$];

    zone_bl_tx #(.ZONES(ZONES), .DW(DW), .CLK_DIV(CLK_DIV), .LATCH_CYC(LATCH_CYC)) dut (
        .i_pix_clk  (i_pix_clk),
        .rst        (rst),
        .zone_valid (zone_valid),
        .zone_idx   (zone_idx),
        .zone_data  (zone_data),
        .frame_sync (frame_sync),
        .led_sclk   (led_sclk),
        .led_sdo    (led_sdo),
        .led_latch  (led_latch),
        .busy       (busy),
        .frame_drop (frame_drop)
    );

    always #5 i_pix_clk = ~i_pix_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] exp_word(input logic [7:0] d);
`ifdef ZONE_TX_PARITY_EN
        return {d, ^d};
`else
        return {1'b0, d};
`endif
    endfunction

    // Monitor state
    int         nbits = 0, zones_rx = 0, busy_cnt = 0, lat_cnt = 0;
    logic [8:0] word = 9'd0;
    logic       prev_sclk = 1'b0, prev_latch = 1'b0;
    logic [8:0] exp_w;
    logic       have;

    // Monitor: assemble bits on sclk rising, compare words, frame length and latch/busy widths.
    always @(negedge i_pix_clk) begin
        if (rst) begin
            exp_q.delete();
            nbits = 0; word = 9'd0; zones_rx = 0; busy_cnt = 0; lat_cnt = 0;
            prev_sclk = 1'b0; prev_latch = 1'b0;
        end else begin
            if (led_sclk && !prev_sclk) begin
                word = {word[7:0], led_sdo};
                nbits++;
                if (nbits == NB) begin
                    have = (exp_q.size() != 0);
                    chk("word_expected", {31'd0, have}, 32'd1);
                    if (have) begin
                        exp_w = exp_q.pop_front();
                        chk("zone_word", {23'd0, word}, {23'd0, exp_w});
                    end
                    zones_rx++;
                    nbits = 0;
                    word  = 9'd0;
                end
            end
            if (led_latch) begin
                if (!prev_latch) begin
                    chk("zones_per_frame", zones_rx, ZONES);
                    chk("bits_at_latch", nbits, 0);
                    zones_rx = 0;
                end
                lat_cnt++;
            end else if (lat_cnt != 0) begin
                chk("latch_width", lat_cnt, LATCH_CYC);
                lat_cnt = 0;
            end
            if (busy) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                chk("busy_width", busy_cnt, FRAME_CYC);
                busy_cnt = 0;
            end
            prev_sclk  = led_sclk;
            prev_latch = led_latch;
        end
    end

    task automatic write_zone(input int idx, input logic [7:0] d);
        @(negedge i_pix_clk);
        zone_valid = 1'b1;
        zone_idx   = 9'(idx);
        zone_data  = d;
        if (idx < ZONES) mdl[mwb][idx] = d;
    endtask

    task automatic end_write();
        @(negedge i_pix_clk);
        zone_valid = 1'b0;
    endtask

    task automatic do_sync(input bit expect_drop, input bit with_write);
        @(negedge i_pix_clk);
        frame_sync = 1'b1;
        if (with_write) begin
            zone_valid = 1'b1;
            zone_idx   = 9'd5;
            zone_data  = 8'hAA;
            mdl[mwb][5] = 8'hAA;
        end
        if (!expect_drop) begin
            for (int z = ZONES - 1; z >= 0; z--) exp_q.push_back(exp_word(mdl[mwb][z]));
            mwb = ~mwb;
        end
        @(negedge i_pix_clk);
        frame_sync = 1'b0;
        zone_valid = 1'b0;
        chk("busy_after_sync", {31'd0, busy}, 32'd1);
        chk("frame_drop_pulse", {31'd0, frame_drop}, {31'd0, expect_drop});
        @(negedge i_pix_clk);
        chk("frame_drop_single", {31'd0, frame_drop}, 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < FRAME_CYC + 1000; i++) begin
            if (!busy) break;
            @(negedge i_pix_clk);
        end
        chk("tx_done_in_time", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge i_pix_clk);
    endtask

    initial begin
        repeat (3) @(negedge i_pix_clk);
        chk("rst_sclk",  {31'd0, led_sclk},   32'd0);
        chk("rst_sdo",   {31'd0, led_sdo},    32'd0);
        chk("rst_latch", {31'd0, led_latch},  32'd0);
        chk("rst_busy",  {31'd0, busy},       32'd0);
        chk("rst_drop",  {31'd0, frame_drop}, 32'd0);
        rst = 1'b0;

        // Frame A: zone i = i[7:0]; a second sync 100 cycles in must be dropped.
        for (int i = 0; i < ZONES; i++) write_zone(i, 8'(i));
        end_write();
        do_sync(1'b0, 1'b0);
        repeat (100) @(negedge i_pix_clk);
        do_sync(1'b1, 1'b0);
        for (int i = 0; i < ZONES; i++) write_zone(i, 8'(255 - i));
        write_zone(360, 8'hFF);
        end_write();
        wait_idle();

        // Frame B: a write in the swap cycle lands in the outgoing frame.
        do_sync(1'b0, 1'b1);
        for (int i = 0; i < ZONES; i++) write_zone(i, 8'(i * 3) ^ 8'h5A);
        end_write();
        repeat (300) @(negedge i_pix_clk);
        for (int i = 0; i < 50; i++) begin
            if (led_sclk) break;
            @(negedge i_pix_clk);
        end
        chk("mid_shift_seen", {31'd0, led_sclk}, 32'd1);
        rst = 1'b1;
        @(negedge i_pix_clk);
        chk("midrst_sclk",  {31'd0, led_sclk},  32'd0);
        chk("midrst_sdo",   {31'd0, led_sdo},   32'd0);
        chk("midrst_busy",  {31'd0, busy},      32'd0);
        chk("midrst_latch", {31'd0, led_latch}, 32'd0);
        rst = 1'b0;
        mwb = 1'b0;

        // Frame C: full rewrite after reset.
        for (int i = 0; i < ZONES; i++) write_zone(i, 8'(i * 7 + 1));
        write_zone(360, 8'h00);
        end_write();
        do_sync(1'b0, 1'b0);
        wait_idle();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
